// File: rtl/rx_msg_assembler_pkg.sv
// rx_msg_assembler_pkg: shared message-type constants, header layout and default widths
// for the receive-side pin deframer.
package rx_msg_assembler_pkg;
    localparam int IO_BITS_DEF         = 4;
    localparam int WORD_BITS_DEF       = 16;
    localparam int MSG_TYPE_BITS_DEF   = 2;
    localparam int MAX_OUTSTANDING_DEF = 3;
    localparam logic [1:0] MSG_TYPE_RSVD  = 2'b00;
    localparam logic [1:0] MSG_TYPE_INSTR = 2'b01;
    localparam logic [1:0] MSG_TYPE_RDATA = 2'b10;
    localparam logic [1:0] MSG_TYPE_WACK  = 2'b11;
    localparam int HDR_START_BIT = IO_BITS_DEF - 1;
    typedef enum logic {ST_IDLE, ST_RECV} state_t;
    // Start bit is always the MSB of the pin bus, whatever its width.
    function automatic int hdr_start_bit(input int io_bits);
        return io_bits - 1;
    endfunction
endpackage

// File: rtl/rx_msg_assembler_credit.sv
// rx_credit_counter: outstanding-request credit tracker.
// Ports: clk, rst_n (sync active-low), req_issued (request pulse), rsp_done (response
// completed), outstanding (in-flight count), can_request, protocol_err (sticky).
module rx_credit_counter #(
    parameter int MAX_OUTSTANDING = 3,
    parameter int CW              = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_issued,
    input  logic          rsp_done,
    output logic [CW-1:0] outstanding,
    output logic          can_request,
    output logic          protocol_err
);
    logic accept;
    assign can_request = outstanding < CW'(MAX_OUTSTANDING);
    assign accept      = req_issued && can_request;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding  <= '0;
            protocol_err <= 1'b0;
        end else begin
            // A simultaneous accept and completion cancel out, even at zero.
            if (accept && !rsp_done)
                outstanding <= outstanding + 1'b1;
            else if (rsp_done && !accept && outstanding != '0)
                outstanding <= outstanding - 1'b1;
            if ((req_issued && !can_request) || (rsp_done && outstanding == '0))
                protocol_err <= 1'b1;
        end
    end
endmodule

// File: rtl/rx_msg_assembler.sv
// rx_msg_assembler: pin deframer that detects headers, assembles payload nibbles LSB-first
// into a tagged word and offers it on a valid/ready output register, with request credits.
// Ports: clk, rst_n (sync active-low), rx_in (pin nibble), req_issued, out_valid/out_ready/
// out_data/out_type (message output), can_request, outstanding, overflow, protocol_err.
module rx_msg_assembler
    import rx_msg_assembler_pkg::*;
#(
    parameter int IO_BITS         = IO_BITS_DEF,
    parameter int WORD_BITS       = WORD_BITS_DEF,
    parameter int MSG_TYPE_BITS   = MSG_TYPE_BITS_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IO_BITS-1:0]       rx_in,
    input  logic                     req_issued,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_BITS-1:0]     out_data,
    output logic [MSG_TYPE_BITS-1:0] out_type,
    output logic                     can_request,
    output logic [1:0]               outstanding,
    output logic                     overflow,
    output logic                     protocol_err
);
    localparam int NIBBLES = WORD_BITS / IO_BITS;
    localparam int CW      = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    localparam int SB      = hdr_start_bit(IO_BITS);

    state_t                   state, state_nx;
    logic [CW-1:0]            cnt;
    logic [MSG_TYPE_BITS-1:0] type_q;
    logic [WORD_BITS-1:0]     asm_q, asm_nx;
    logic                     hdr, is_wack, last, rsp_done, pop, load;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = (state == ST_IDLE) ? ((hdr && !is_wack) ? ST_RECV : ST_IDLE)
                                      : (last ? ST_IDLE : ST_RECV);
    end

    always_comb begin
        hdr      = (state == ST_IDLE) && rx_in[SB];
        is_wack  = rx_in[MSG_TYPE_BITS-1:0] == MSG_TYPE_BITS'(MSG_TYPE_WACK);
        last     = (state == ST_RECV) && (cnt == CW'(NIBBLES - 1));
        rsp_done = last || (hdr && is_wack);
        pop      = out_valid && out_ready;
        // A finished word may replace the held one only if that one leaves this cycle.
        load     = last && (!out_valid || out_ready);
        asm_nx   = asm_q;
        asm_nx[cnt*IO_BITS +: IO_BITS] = rx_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            type_q    <= '0;
            asm_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_type  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (hdr && !is_wack) begin
                type_q <= rx_in[MSG_TYPE_BITS-1:0];
                cnt    <= '0;
            end else if (state == ST_RECV) begin
                asm_q <= asm_nx;
                cnt   <= last ? '0 : cnt + 1'b1;
            end
            out_valid <= load ? 1'b1 : (pop ? 1'b0 : out_valid);
            if (load) begin
                out_data <= asm_nx;
                out_type <= type_q;
            end
            if (last && !load) overflow <= 1'b1;
        end
    end

    rx_credit_counter #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CW             (2)
    ) u_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_issued  (req_issued),
        .rsp_done    (rsp_done),
        .outstanding (outstanding),
        .can_request (can_request),
        .protocol_err(protocol_err)
    );
endmodule
